// File: rtl/conv_pkg.sv
// Shared types and defaults for the convolution host sequencer and its read streamer.
package conv_pkg;

  localparam int DW_DEF  = 8;
  localparam int AW_DEF  = 5;
  localparam int ZW_DEF  = 16;
  localparam int TMO_DEF = 4095;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD_X,
    S_LOAD_Y,
    S_START,
    S_WAIT_DONE,
    S_RD_REQ,
    S_RD_WAIT,
    S_STREAM,
    S_FINISH
  } state_e;

endpackage

// File: rtl/conv_rd_streamer.sv
// Reads NZ results from Z memory (one-cycle latency) and presents them on a
// valid/ready stream, one result per three cycles at best.
module conv_rd_streamer
  import conv_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int ZW = ZW_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          launch_i,
  input  logic [AW+1:0] nz_i,
  output logic [AW:0]   z_addr_o,
  output logic          z_re_o,
  input  logic [ZW-1:0] z_rdata_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [ZW-1:0] out_data_o,
  output logic          out_last_o,
  output logic          fin_o
);

  state_e        state_q, state_d;
  logic [AW:0]   idx_q, idx_d;
  logic [AW+1:0] nz_q, nz_d;
  logic [ZW-1:0] data_q, data_d;
  logic          last;

  assign last       = ({1'b0, idx_q} == nz_q - 1'b1);
  assign z_addr_o   = idx_q;
  assign out_data_o = data_q;
  assign out_last_o = (state_q == S_STREAM) && last;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      nz_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nz_q    <= nz_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    nz_d        = nz_q;
    data_d      = data_q;
    z_re_o      = 1'b0;
    out_valid_o = 1'b0;
    fin_o       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (launch_i) begin
          idx_d   = '0;
          nz_d    = nz_i;
          state_d = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        z_re_o  = 1'b1;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        data_d  = z_rdata_i;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        // data_q is only reloaded in RD_WAIT, so it stays put under backpressure
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          if (last) begin
            fin_o   = 1'b1;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_RD_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: rtl/conv_host_sequencer.sv
// Host-side job sequencer: loads X/Y into memory, kicks the convolution engine,
// guards it with a watchdog, then streams the Z results out.
module conv_host_sequencer
  import conv_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int AW  = AW_DEF,
  parameter int ZW  = ZW_DEF,
  parameter int TMO = TMO_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          go,
  input  logic [AW:0]   len_x,
  input  logic [AW:0]   len_y,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          x_we,
  output logic          y_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          conv_start,
  input  logic          conv_busy,
  input  logic          conv_done,
  output logic [AW:0]   z_addr,
  output logic          z_re,
  input  logic [ZW-1:0] z_rdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [ZW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam int             WDW     = $clog2(TMO + 1);
  localparam logic [WDW-1:0] TMO_L   = WDW'(TMO);
  localparam logic [AW:0]    LEN_MAX = {1'b1, {AW{1'b0}}};

  state_e         state_q, state_d;
  logic [AW:0]    cnt_q, cnt_d;
  logic [AW:0]    lenx_q, lenx_d;
  logic [AW:0]    leny_q, leny_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           err_q, err_d;
  logic [AW+1:0]  nz;
  logic           len_ok, launch, rd_fin;
  // Engine progress is tracked by conv_done and the watchdog alone.
  logic           unused_conv_busy;

  assign unused_conv_busy = conv_busy;
  assign nz     = ({1'b0, lenx_q} + {1'b0, leny_q}) - 1'b1;
  assign len_ok = (len_x != '0) && (len_x <= LEN_MAX) &&
                  (len_y != '0) && (len_y <= LEN_MAX);
  assign busy   = (state_q != S_IDLE);
  assign error  = err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lenx_q  <= '0;
      leny_q  <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lenx_q  <= lenx_d;
      leny_q  <= leny_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lenx_d     = lenx_q;
    leny_d     = leny_q;
    wdog_d     = wdog_q;
    err_d      = err_q;
    in_ready   = 1'b0;
    x_we       = 1'b0;
    y_we       = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    conv_start = 1'b0;
    launch     = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          if (len_ok) begin
            err_d   = 1'b0;
            lenx_d  = len_x;
            leny_d  = len_y;
            cnt_d   = '0;
            state_d = S_LOAD_X;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD_X, S_LOAD_Y: begin
        in_ready = 1'b1;
        if (in_valid) begin
          x_we      = (state_q == S_LOAD_X);
          y_we      = (state_q == S_LOAD_Y);
          mem_addr  = cnt_q[AW-1:0];
          mem_wdata = in_data;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == ((state_q == S_LOAD_X) ? lenx_q : leny_q) - 1'b1) begin
            cnt_d   = '0;
            state_d = (state_q == S_LOAD_X) ? S_LOAD_Y : S_START;
          end
        end
      end
      S_START: begin
        conv_start = 1'b1;
        wdog_d     = '0;
        state_d    = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // conv_start drops combinationally in the cycle done or timeout is seen
        if (conv_done) begin
          launch  = 1'b1;
          state_d = S_RD_REQ;
        end else if (wdog_q + 1'b1 == TMO_L) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          conv_start = 1'b1;
          wdog_d     = wdog_q + 1'b1;
        end
      end
      S_RD_REQ: begin
        // the streamer owns RD_REQ/RD_WAIT/STREAM; wait for its last handshake
        if (rd_fin) state_d = S_FINISH;
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  conv_rd_streamer #(
    .AW (AW),
    .ZW (ZW)
  ) u_rd_streamer (
    .clk         (clk),
    .rstn        (rstn),
    .launch_i    (launch),
    .nz_i        (nz),
    .z_addr_o    (z_addr),
    .z_re_o      (z_re),
    .z_rdata_i   (z_rdata),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_last_o  (out_last),
    .fin_o       (rd_fin)
  );

endmodule

// File: tb/tb_conv_host_sequencer.sv
// Directed bench for conv_host_sequencer with a simple engine and Z-memory model.
module tb_conv_host_sequencer;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int ZW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          go = 1'b0;
  logic [AW:0]   len_x = '0;
  logic [AW:0]   len_y = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          x_we, y_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          conv_start;
  logic          conv_busy = 1'b0;
  logic          conv_done = 1'b0;
  logic [AW:0]   z_addr;
  logic          z_re;
  logic [ZW-1:0] z_rdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [ZW-1:0] out_data;
  logic          out_last;
  logic          busy, done, error;

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] xmem [32];
  logic [DW-1:0] ymem [32];
  logic [ZW-1:0] zmem [64];
  int  xw_addr [$];
  int  yw_addr [$];
  int  we_cnt = 0;
  int  done_cnt = 0;
  int  busy_cnt = 0;
  int  eng_cnt = 0;
  bit  eng_en = 1'b1;
  int  exp_z [64];

  always #5 clk = ~clk;

  conv_host_sequencer #(.DW(DW), .AW(AW), .ZW(ZW), .TMO(15)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .go         (go),
    .len_x      (len_x),
    .len_y      (len_y),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .x_we       (x_we),
    .y_we       (y_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .conv_start (conv_start),
    .conv_busy  (conv_busy),
    .conv_done  (conv_done),
    .z_addr     (z_addr),
    .z_re       (z_re),
    .z_rdata    (z_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  // X/Y memory capture and event monitors
  always @(posedge clk) begin
    if (x_we) begin
      xmem[mem_addr] <= mem_wdata;
      xw_addr.push_back(int'(mem_addr));
    end
    if (y_we) begin
      ymem[mem_addr] <= mem_wdata;
      yw_addr.push_back(int'(mem_addr));
    end
    if (x_we || y_we) we_cnt <= we_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  // Engine: answers conv_done four cycles into conv_start when enabled
  always @(posedge clk) begin
    conv_done <= 1'b0;
    conv_busy <= conv_start;
    if (!conv_start) eng_cnt <= 0;
    else if (eng_en) begin
      eng_cnt <= eng_cnt + 1;
      if (eng_cnt == 3) conv_done <= 1'b1;
    end
  end

  // Z memory with one-cycle read latency
  always @(posedge clk) begin
    if (z_re) z_rdata <= zmem[z_addr];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    logic [44:0] v;
    v = {in_ready, x_we, y_we, mem_addr, mem_wdata, conv_start, z_re, z_addr,
         out_valid, out_data, out_last, busy, done, error};
    chk(tag, 64'(v), 64'd0);
  endtask

  task automatic go_job(input int lx, input int ly);
    @(posedge clk); #1;
    len_x = (AW+1)'(lx);
    len_y = (AW+1)'(ly);
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit gap);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    in_valid = 1'b1;
    in_data = d;
    while (!acc && tries < 20) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      tries++;
    end
    chk("beat_accept", 64'(acc), 64'd1);
    in_valid = 1'b0;
    in_data = '0;
    if (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic engine_compute(input int lx, input int ly);
    for (int k = 0; k < 64; k++) begin
      int acc;
      acc = 0;
      for (int i = 0; i < lx; i++)
        if (k - i >= 0 && k - i < ly) acc += int'(xmem[i]) * int'(ymem[k-i]);
      zmem[k] = acc[15:0];
    end
  endtask

  task automatic recv(input int n, input int stall_at);
    for (int i = 0; i < n; i++) begin
      int w;
      w = 0;
      @(negedge clk);
      while (!out_valid && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("beat_valid", 64'(out_valid), 64'd1);
      if (i == stall_at) begin
        int nbad;
        nbad = 0;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (!out_valid || out_data != ZW'(exp_z[i])) nbad++;
        end
        chk("stall_stable", 64'(nbad), 64'd0);
      end
      chk($sformatf("beat%0d_data", i), 64'(out_data), 64'(exp_z[i]));
      chk($sformatf("beat%0d_last", i), 64'(out_last), 64'(i == n - 1));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not end, required end before 50000 cycles");
    $fatal(1);
  end

  initial begin
    int d0, we0, b0, qx0, qy0, w;
    // Reset with noisy inputs
    go = 1'b1; len_x = 7'd3; len_y = 7'd2; in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_quiet("reset_outputs");
    go = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", 64'(busy), 64'd0);

    // Job 1: X{1,2,3}, Y{1,1}, in_valid every other cycle
    d0 = done_cnt; we0 = we_cnt; qx0 = xw_addr.size(); qy0 = yw_addr.size();
    go_job(3, 2);
    chk("job1_busy", 64'(busy), 64'd1);
    send(8'd1, 1'b1); send(8'd2, 1'b1); send(8'd3, 1'b1);
    send(8'd1, 1'b1); send(8'd1, 1'b1);
    chk("job1_wr_count", 64'(we_cnt - we0), 64'd5);
    chk("job1_x_count", 64'(xw_addr.size() - qx0), 64'd3);
    chk("job1_y_count", 64'(yw_addr.size() - qy0), 64'd2);
    for (int i = 0; i < 3; i++) chk($sformatf("job1_xaddr%0d", i), 64'(xw_addr[qx0+i]), 64'(i));
    for (int i = 0; i < 2; i++) chk($sformatf("job1_yaddr%0d", i), 64'(yw_addr[qy0+i]), 64'(i));
    engine_compute(3, 2);
    exp_z[0] = 1; exp_z[1] = 3; exp_z[2] = 5; exp_z[3] = 3;
    recv(4, -1);
    repeat (4) @(posedge clk); #1;
    chk("job1_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("job1_idle", 64'(busy), 64'd0);
    chk("job1_error", 64'(error), 64'd0);
    chk("job1_no_extra_beat", 64'(out_valid), 64'd0);

    // Job 2: X{4,0,2}, Y{3,1}, stray go mid-load, 10-cycle stall on beat 1
    d0 = done_cnt;
    go_job(3, 2);
    send(8'd4, 1'b0);
    go = 1'b1; len_x = '0;
    send(8'd0, 1'b0);
    go = 1'b0;
    send(8'd2, 1'b0); send(8'd3, 1'b0); send(8'd1, 1'b0);
    engine_compute(3, 2);
    exp_z[0] = 12; exp_z[1] = 4; exp_z[2] = 6; exp_z[3] = 2;
    recv(4, 1);
    repeat (4) @(posedge clk); #1;
    chk("job2_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("job2_error", 64'(error), 64'd0);

    // Zero length request
    we0 = we_cnt; b0 = busy_cnt;
    go_job(0, 2);
    chk("badgo_error", 64'(error), 64'd1);
    chk("badgo_busy", 64'(busy), 64'd0);
    repeat (5) @(posedge clk); #1;
    chk("badgo_no_writes", 64'(we_cnt - we0), 64'd0);
    chk("badgo_busy_cycles", 64'(busy_cnt - b0), 64'd0);

    // Job 3: maximum lengths 32x32, all ones
    d0 = done_cnt; we0 = we_cnt; qx0 = xw_addr.size(); qy0 = yw_addr.size();
    go_job(32, 32);
    chk("job3_error_cleared", 64'(error), 64'd0);
    for (int i = 0; i < 64; i++) send(8'd1, 1'b0);
    chk("job3_wr_count", 64'(we_cnt - we0), 64'd64);
    chk("job3_x_last_addr", 64'(xw_addr[qx0+31]), 64'd31);
    chk("job3_y_last_addr", 64'(yw_addr[qy0+31]), 64'd31);
    engine_compute(32, 32);
    for (int k = 0; k < 63; k++) exp_z[k] = (k < 32) ? k + 1 : 63 - k;
    recv(63, -1);
    repeat (4) @(posedge clk); #1;
    chk("job3_done_pulses", 64'(done_cnt - d0), 64'd1);

    // Watchdog: engine silent
    eng_en = 1'b0;
    d0 = done_cnt;
    go_job(1, 1);
    send(8'd7, 1'b0); send(8'd1, 1'b0);
    w = 0;
    @(negedge clk);
    while (!conv_start && w < 20) begin @(negedge clk); w++; end
    chk("tmo_start_seen", 64'(conv_start), 64'd1);
    w = 0;
    while (!(error && !conv_start) && w < 40) begin @(negedge clk); w++; end
    chk("tmo_window", 64'(w >= 15 && w <= 16), 64'd1);
    chk("tmo_error", 64'(error), 64'd1);
    chk("tmo_start_low", 64'(conv_start), 64'd0);
    repeat (4) @(posedge clk); #1;
    chk("tmo_done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("tmo_error_sticky", 64'(error), 64'd1);

    // Reset during WAIT_DONE
    go_job(1, 1);
    send(8'd2, 1'b0); send(8'd2, 1'b0);
    w = 0;
    @(negedge clk);
    while (!conv_start && w < 20) begin @(negedge clk); w++; end
    @(negedge clk);
    chk("rst_mid_in_wait", 64'(conv_start), 64'd1);
    rstn = 1'b0;
    #1;
    check_quiet("rst_mid_outputs");
    @(negedge clk);
    check_quiet("rst_mid_outputs_next");
    @(posedge clk); #1;
    rstn = 1'b1;
    d0 = done_cnt;
    repeat (10) @(posedge clk); #1;
    chk("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
    chk("rst_mid_idle", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
